md6_n_stream: RTL and testbench

Streaming successor to the MD6 compression-input assembler. It accepts message words over a valid/ready stream and collects them into 64-word data blocks B. For each block it computes the padding count p, the z flag and a running index, and emits the complete 89-word N vector (Q | K | U | V | B) over a valid/ready handshake to the compression-function core. A SEQ parameter selects parallel (PAR) or sequential (SEQ) chaining mode.

---
 rtl/md6_n_stream.sv | 201 ++++++++++++++++++++
 tb/tb_md6_n_stream.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md6_n_stream.sv
// MD6 N-vector stream assembler: packs message words into 64-word B blocks and
// emits Q | K | U | V | B per block over a valid/ready handshake.

`ifndef MD6_W
`define MD6_W 64
`endif

`ifndef Q_array
`define Q_array {64'h0d6f3522631effcb, 64'h3b72066c7a1552ac, 64'hc878c1dd04c4b633, 64'h995ad1178bd25c31, 64'h8af8671d3fb50c2c, 64'h3e7f16bb88222e0d, 64'h4ad12aae0a6d6031, 64'h54e5ed5b88e3775d, 64'h1f8ccf6823058f8a, 64'h0cd0d63b2c30bc41, 64'hdd2e76cba691e5bf, 64'he8fb23908d9f06f1, 64'hb60450e9ef68b7c1, 64'h6432286434aac8e7, 64'h7311c2812425cfa0}
`endif

module md6_n_stream #(
    parameter int SEQ = 0,
    parameter int C   = 16,
    parameter int BW  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         empty_msg,
    input  logic [11:0]                  r,
    input  logic [7:0]                   L,
    input  logic [7:0]                   level,
    input  logic [11:0]                  d,
    input  logic [8*`MD6_W-1:0]          K,
    input  logic [7:0]                   keylen,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [`MD6_W-1:0]            in_data,
    input  logic                         in_last,
    input  logic                         chain_valid,
    output logic                         chain_ready,
    input  logic [C*`MD6_W-1:0]          chain_in,
    output logic                         n_valid,
    input  logic                         n_ready,
    output logic [(25+BW)*`MD6_W-1:0]    n_out,
    output logic                         busy,
    output logic                         done
);

    localparam int MW   = (SEQ != 0) ? (BW - C) : BW;
    localparam int BASE = (SEQ != 0) ? C : 0;
    localparam int CW   = $clog2(BW + 1);
    localparam int WI   = $clog2(BW);
    localparam logic [15*`MD6_W-1:0] Q_WORDS = `Q_array;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_EMIT  = 2'd2,
        ST_CHAIN = 2'd3
    } state_t;

    state_t                       state_r;
    logic [11:0]                  r_r;
    logic [7:0]                   l_r;
    logic [7:0]                   level_r;
    logic [11:0]                  d_r;
    logic [8*`MD6_W-1:0]          k_r;
    logic [7:0]                   keylen_r;
    logic [55:0]                  index_r;
    logic [CW-1:0]                count_r;
    logic                         last_r;
    logic [BW-1:0][`MD6_W-1:0]    b_r;
    logic                         in_ready_r;
    logic                         chain_ready_r;
    logic                         n_valid_r;
    logic                         busy_r;
    logic                         done_r;

    logic                         accept_s;
    logic                         close_s;
    logic [CW-1:0]                next_count_s;
    logic [WI-1:0]                wr_idx_s;
    logic [15:0]                  p_s;
    logic                         z_s;
    logic [`MD6_W-1:0]            u_s;
    logic [`MD6_W-1:0]            v_s;

    // Word-accept decode and the per-block U/V field arithmetic
    always_comb begin
        accept_s     = in_valid & in_ready_r;
        next_count_s = count_r + CW'(1);
        wr_idx_s     = WI'(BASE) + WI'(count_r);
        close_s      = accept_s & ((next_count_s == CW'(MW)) | in_last);
        p_s          = (16'(MW) - 16'(count_r)) * 16'(`MD6_W);
        if (SEQ != 0) begin
            z_s = last_r;
        end else begin
            z_s = last_r & (index_r == 56'd0);
        end
        u_s = {level_r, index_r};
        v_s = {4'b0000, r_r, l_r, 3'b000, z_s, p_s, keylen_r, d_r};
    end

    assign n_out       = {b_r, v_s, u_s, k_r, Q_WORDS};
    assign in_ready    = in_ready_r;
    assign chain_ready = chain_ready_r;
    assign n_valid     = n_valid_r;
    assign busy        = busy_r;
    assign done        = done_r;

    // Block sequencing FSM with registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            r_r           <= 12'd0;
            l_r           <= 8'd0;
            level_r       <= 8'd0;
            d_r           <= 12'd0;
            k_r           <= '0;
            keylen_r      <= 8'd0;
            index_r       <= 56'd0;
            count_r       <= '0;
            last_r        <= 1'b0;
            b_r           <= '0;
            in_ready_r    <= 1'b0;
            chain_ready_r <= 1'b0;
            n_valid_r     <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        r_r      <= r;
                        l_r      <= L;
                        level_r  <= level;
                        d_r      <= d;
                        k_r      <= K;
                        keylen_r <= keylen;
                        index_r  <= 56'd0;
                        count_r  <= '0;
                        b_r      <= '0;
                        busy_r   <= 1'b1;
                        if (empty_msg) begin
                            last_r    <= 1'b1;
                            n_valid_r <= 1'b1;
                            state_r   <= ST_EMIT;
                        end else begin
                            last_r     <= 1'b0;
                            in_ready_r <= 1'b1;
                            state_r    <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        b_r[wr_idx_s] <= in_data;
                        count_r       <= next_count_s;
                        if (close_s) begin
                            last_r     <= in_last;
                            in_ready_r <= 1'b0;
                            n_valid_r  <= 1'b1;
                            state_r    <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    if (n_ready) begin
                        index_r   <= index_r + 56'd1;
                        b_r       <= '0;
                        count_r   <= '0;
                        n_valid_r <= 1'b0;
                        if (last_r) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_IDLE;
                        end else if (SEQ != 0) begin
                            chain_ready_r <= 1'b1;
                            state_r       <= ST_CHAIN;
                        end else begin
                            in_ready_r <= 1'b1;
                            state_r    <= ST_LOAD;
                        end
                    end
                end
                ST_CHAIN: begin
                    // Previous compression output seeds the leading C words of the next B
                    if (chain_valid) begin
                        for (int j = 0; j < C; j++) begin
                            b_r[j] <= chain_in[j*`MD6_W +: `MD6_W];
                        end
                        chain_ready_r <= 1'b0;
                        in_ready_r    <= 1'b1;
                        state_r       <= ST_LOAD;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    in_ready_r    <= 1'b0;
                    chain_ready_r <= 1'b0;
                    n_valid_r     <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md6_n_stream.sv
// Bench for md6_n_stream: a message-level model predicts every N vector for a
// PAR and a SEQ instance; one compare process checks them each cycle.

module tb_md6_n_stream;

    localparam int W  = 64;
    localparam int NW = 89;
    localparam logic [W-1:0] Q_TAB [15] = '{
        64'h7311c2812425cfa0, 64'h6432286434aac8e7, 64'hb60450e9ef68b7c1,
        64'he8fb23908d9f06f1, 64'hdd2e76cba691e5bf, 64'h0cd0d63b2c30bc41,
        64'h1f8ccf6823058f8a, 64'h54e5ed5b88e3775d, 64'h4ad12aae0a6d6031,
        64'h3e7f16bb88222e0d, 64'h8af8671d3fb50c2c, 64'h995ad1178bd25c31,
        64'hc878c1dd04c4b633, 64'h3b72066c7a1552ac, 64'h0d6f3522631effcb};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, start, empty_msg, sel;
    logic [11:0]       cfg_r, cfg_d;
    logic [7:0]        cfg_l, cfg_level, cfg_keylen;
    logic [8*W-1:0]    cfg_k;
    logic              in_valid, in_last, chain_valid, n_ready;
    logic [W-1:0]      in_data;
    logic [16*W-1:0]   chain_in;
    logic              start_p, start_s;
    logic              p_in_ready, p_chain_ready, p_n_valid, p_busy, p_done;
    logic              s_in_ready, s_chain_ready, s_n_valid, s_busy, s_done;
    logic [NW*W-1:0]   p_n_out, s_n_out;
    logic              in_ready_m, chain_ready_m, n_valid_m, busy_m, done_m;
    logic [NW*W-1:0]   n_out_m;

    assign start_p       = start & ~sel;
    assign start_s       = start & sel;
    assign in_ready_m    = sel ? s_in_ready    : p_in_ready;
    assign chain_ready_m = sel ? s_chain_ready : p_chain_ready;
    assign n_valid_m     = sel ? s_n_valid     : p_n_valid;
    assign busy_m        = sel ? s_busy        : p_busy;
    assign done_m        = sel ? s_done        : p_done;
    assign n_out_m       = sel ? s_n_out       : p_n_out;

    md6_n_stream #(.SEQ(0), .C(16), .BW(64)) dut_par (
        .clk(clk), .rst(rst), .start(start_p), .empty_msg(empty_msg),
        .r(cfg_r), .L(cfg_l), .level(cfg_level), .d(cfg_d), .K(cfg_k), .keylen(cfg_keylen),
        .in_valid(in_valid), .in_ready(p_in_ready), .in_data(in_data), .in_last(in_last),
        .chain_valid(chain_valid), .chain_ready(p_chain_ready), .chain_in(chain_in),
        .n_valid(p_n_valid), .n_ready(n_ready), .n_out(p_n_out), .busy(p_busy), .done(p_done));

    md6_n_stream #(.SEQ(1), .C(16), .BW(64)) dut_seq (
        .clk(clk), .rst(rst), .start(start_s), .empty_msg(empty_msg),
        .r(cfg_r), .L(cfg_l), .level(cfg_level), .d(cfg_d), .K(cfg_k), .keylen(cfg_keylen),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_last(in_last),
        .chain_valid(chain_valid), .chain_ready(s_chain_ready), .chain_in(chain_in),
        .n_valid(s_n_valid), .n_ready(n_ready), .n_out(s_n_out), .busy(s_busy), .done(s_done));

    typedef struct {
        logic [NW*W-1:0] n;
        bit              last;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] msg[$];
    int           checks = 0;
    int           failures = 0;
    bit           pend_done = 1'b0;
    bit           hold_req = 1'b0;
    int           hold_cnt = 0;

    function automatic logic [W-1:0] chain_word(int j);
        return 64'hA5A5A5A5_00000000 | 64'(j);
    endfunction

    function automatic logic [W-1:0] k_word(int k);
        return 64'hC0DE0000_00000000 + 64'(k);
    endfunction

    function automatic logic [W-1:0] ew(int e, int k);
        logic [NW*W-1:0] t;
        t = exp_q[e].n;
        return t[k*W +: W];
    endfunction

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Message-level model: split msg into blocks and build each expected N
    task automatic build_model(bit seq, int n);
        int mw, base, nb;
        mw   = seq ? 48 : 64;
        base = seq ? 16 : 0;
        nb   = (n == 0) ? 1 : (n + mw - 1) / mw;
        for (int b = 0; b < nb; b++) begin
            exp_t         e;
            logic [W-1:0] wv [NW];
            int           cnt;
            bit           last, z;
            logic [15:0]  p;
            cnt  = (n - b * mw > mw) ? mw : n - b * mw;
            last = (b == nb - 1);
            z    = last && (seq || b == 0);
            p    = 16'((mw - cnt) * 64);
            for (int k = 0; k < NW; k++) wv[k] = '0;
            for (int k = 0; k < 15; k++) wv[k] = Q_TAB[k];
            for (int k = 0; k < 8; k++) wv[15 + k] = k_word(k);
            wv[23] = {cfg_level, 56'(b)};
            wv[24] = {4'h0, cfg_r, cfg_l, 3'b000, z, p, cfg_keylen, cfg_d};
            if (seq && b > 0) begin
                for (int j = 0; j < 16; j++) wv[25 + j] = chain_word(j);
            end
            for (int i = 0; i < cnt; i++) wv[25 + base + i] = msg[b * mw + i];
            for (int k = 0; k < NW; k++) e.n[k*W +: W] = wv[k];
            e.last = last;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_msg(bit seq, int n_drive, int n_total, bit empty);
        int mw, cnt;
        bit ok, accepted;
        mw  = seq ? 48 : 64;
        cnt = 0;
        @(posedge clk); #1;
        sel = seq; start = 1'b1; empty_msg = empty;
        @(posedge clk); #1;
        start = 1'b0; empty_msg = 1'b0;
        if (empty) check("empty_latency", 64'(n_valid_m), 64'd1);
        for (int i = 0; i < n_drive; i++) begin
            in_valid = 1'b1;
            in_data  = msg[i];
            in_last  = (i == n_total - 1);
            accepted = 1'b0;
            for (int t = 0; t < 1000 && !accepted; t++) begin
                @(negedge clk);
                ok = in_ready_m;
                @(posedge clk); #1;
                accepted = ok;
            end
            if (!accepted) begin
                checks++; failures++;
                $display("FAIL word_accept_timeout: word %0d never accepted", i);
                break;
            end
            cnt++;
            if (cnt == mw || in_last) begin
                check("close_latency", 64'(n_valid_m), 64'd1);
                cnt = 0;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int t = 0; t < 3000 && !idle; t++) begin
            @(negedge clk);
            idle = (exp_q.size() == 0) && !busy_m && !pend_done;
        end
        if (!idle) begin
            checks++; failures++;
            $display("FAIL drain_timeout: %0d N vectors still expected", exp_q.size());
        end
    endtask

    // Downstream ready: optionally stall the first emitted N for 10 cycles
    initial begin
        n_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (hold_req && n_valid_m && hold_cnt < 10) begin
                n_ready = 1'b0;
                hold_cnt++;
            end else begin
                n_ready = 1'b1;
            end
        end
    end

    // Compare process: N contents, emit/in_ready exclusion and done timing
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_done = 1'b0;
                continue;
            end
            if (pend_done) begin
                check("done_pulse_busy_low", {62'd0, done_m, busy_m}, 64'd2);
                pend_done = 1'b0;
            end else begin
                check("done_low", 64'(done_m), 64'd0);
            end
            if (n_valid_m) begin
                check("in_ready_low_in_emit", 64'(in_ready_m), 64'd0);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_n: n_valid high with no N expected");
                end else begin
                    logic [NW*W-1:0] cur;
                    int bad;
                    bit lst;
                    cur = exp_q[0].n;
                    bad = -1;
                    for (int k = 0; k < NW; k++) begin
                        if (bad < 0 && n_out_m[k*W +: W] !== cur[k*W +: W]) bad = k;
                    end
                    if (bad >= 0) begin
                        failures++;
                        $display("FAIL n_vector word %0d: got %h expected %h",
                                 bad, n_out_m[bad*W +: W], cur[bad*W +: W]);
                    end
                    if (n_ready) begin
                        lst = exp_q[0].last;
                        void'(exp_q.pop_front());
                        if (lst) pend_done = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; empty_msg = 1'b0; sel = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        chain_valid = 1'b1;
        cfg_r = 12'h028; cfg_l = 8'h40; cfg_level = 8'h03; cfg_d = 12'h100; cfg_keylen = 8'h20;
        for (int k = 0; k < 8; k++) cfg_k[k*W +: W] = k_word(k);
        for (int j = 0; j < 16; j++) chain_in[j*W +: W] = chain_word(j);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_par_outputs", {59'd0, p_in_ready, p_chain_ready, p_n_valid, p_busy, p_done}, 64'd0);
        check("reset_seq_outputs", {59'd0, s_in_ready, s_chain_ready, s_n_valid, s_busy, s_done}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // PAR, exactly 64 words ending with in_last
        msg.delete();
        for (int k = 0; k < 64; k++) msg.push_back(64'(k + 1));
        build_model(1'b0, 64);
        check("model_t1_v", ew(0, 24), 64'h0028401000020100);
        check("model_t1_u", ew(0, 23), 64'h0300000000000000);
        check("model_t1_b63", ew(0, 88), 64'd64);
        drive_msg(1'b0, 64, 64, 1'b0);
        wait_idle();

        // PAR, 100 words with the first N stalled for 10 cycles
        msg.delete();
        for (int k = 0; k < 100; k++) msg.push_back(64'h100 + 64'(k));
        build_model(1'b0, 100);
        check("model_t2_v0", ew(0, 24), 64'h0028400000020100);
        check("model_t2_v1", ew(1, 24), 64'h0028400070020100);
        check("model_t2_u1", ew(1, 23), 64'h0300000000000001);
        check("model_t2_b36", ew(1, 25 + 36), 64'd0);
        hold_cnt = 0;
        hold_req = 1'b1;
        drive_msg(1'b0, 100, 100, 1'b0);
        wait_idle();
        hold_req = 1'b0;
        check("hold_cycles", 64'(hold_cnt), 64'd10);

        // PAR, empty message
        msg.delete();
        build_model(1'b0, 0);
        check("model_t3_v", ew(0, 24), 64'h0028401100020100);
        drive_msg(1'b0, 0, 0, 1'b1);
        wait_idle();

        // SEQ, 60 words across two blocks with a chain handshake between
        msg.delete();
        for (int k = 0; k < 60; k++) msg.push_back(64'h5000 + 64'(k));
        build_model(1'b1, 60);
        check("model_t4_v0", ew(0, 24), 64'h0028400000020100);
        check("model_t4_b0_0", ew(0, 25), 64'd0);
        check("model_t4_b0_16", ew(0, 41), 64'h5000);
        check("model_t4_v1", ew(1, 24), 64'h0028401090020100);
        check("model_t4_b1_0", ew(1, 25), 64'hA5A5A5A500000000);
        check("model_t4_b1_16", ew(1, 41), 64'h5030);
        drive_msg(1'b1, 60, 60, 1'b0);
        wait_idle();

        // Reset mid-block, then a fresh short message
        msg.delete();
        for (int k = 0; k < 40; k++) msg.push_back(64'h900 + 64'(k));
        drive_msg(1'b0, 30, 40, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_reset_outputs", {59'd0, in_ready_m, chain_ready_m, n_valid_m, busy_m, done_m}, 64'd0);
        exp_q.delete();
        rst = 1'b0;
        msg.delete();
        for (int k = 0; k < 5; k++) msg.push_back(64'h77 + 64'(k));
        build_model(1'b0, 5);
        check("model_t5_u", ew(0, 23), 64'h0300000000000000);
        check("model_t5_v", ew(0, 24), 64'h00284010EC020100);
        drive_msg(1'b0, 5, 5, 1'b0);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
